lut_u_arbiter: RTL and testbench
================================

# lut_u_arbiter

Round-robin arbiter and read sequencer sharing one `lut_u` read port (16-bit data, 8-bit address, asynchronous read) between up to N_REQ requesters in the arithmetic-encoder datapath. Each request is one address, a one-cycle valid/ready handshake per requester. The block registers the granted address onto the LUT, captures the LUT data, and returns it tagged with a one-hot valid to the originating requester. One access is accepted per cycle, fully pipelined.

## Interface
- N_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 16: LUT word width.
- ADDR_WIDTH, 8: LUT address width.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  when high, no new request is accepted; in-flight accesses complete.
- req_valid  in  N_REQ  per-requester request valid.
- req_addr  in  N_REQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  N_REQ  one-hot (or zero) grant; a transfer occurs when req_valid[i] && req_ready[i].
- lut_addr  out  ADDR_WIDTH  registered address driven to `lut_u.addr`.
- lut_q  in  DATA_WIDTH  `lut_u.q`, combinational from lut_addr.
- rsp_valid  out  N_REQ  one-hot response strobe, one cycle per accepted request.
- rsp_data  out  DATA_WIDTH  LUT word for the requester flagged in rsp_valid.

## Operation
- Arbitration is combinational: among req_valid bits, grant the first set bit at or after pointer `rr_ptr`, scanning upward with wrap (N_REQ-1 -> 0).
- req_ready is all-zero when reset, hold, or no req_valid is high. At most one bit is set.
- On transfer from requester g: the access stage loads s1_valid=1, s1_id=g, lut_addr=req_addr[g]; rr_ptr <= (g+1) mod N_REQ. With no transfer, s1_valid <= 0, and lut_addr and rr_ptr hold.
- The response stage, when s1_valid is set, samples lut_q into rsp_data and raises rsp_valid[s1_id] for exactly one cycle. rsp_data holds its last value when rsp_valid is zero.
- Responses have no backpressure; requesters must accept rsp_valid when it fires. Responses return in acceptance order.
- A requester may hold req_valid across grants to issue back-to-back accesses. It is re-granted only after every other active requester has been served once.
- hold asserted mid-stream: accesses already accepted still produce responses. req_ready drops in the same cycle hold rises.
- Reset mid-operation discards all in-flight accesses; no response is produced for them.

## Timing
- Reset values: req_ready=0, lut_addr=0, rsp_valid=0, rsp_data=0, rr_ptr=0, s1_valid=0.
- Default latency: transfer in cycle T drives lut_addr in T+1, and rsp_valid/rsp_data in T+2.
- Throughput is 1 access per cycle with no bubbles between different or identical requesters.
- In the same cycle, the arbiter samples the current rr_ptr, so a requester granted in T has lowest priority in T+1.

## Configuration
- `LUT_U_ARB_RSP_REG_EN` defined: the response stage is registered as above, latency 2. This is for timing closure when lut_u maps to logic with a long read path.
- Undefined: rsp_valid = one-hot(s1_id) & s1_valid, and rsp_data = lut_q, both combinational in T+1, giving latency 1. rsp_data is then valid only while rsp_valid is set. All other behaviour is identical.

## Structure
- Shared package `lut_u_pkg` holds:
  - LUT_DATA_WIDTH=16 and LUT_ADDR_WIDTH=8;
  - typedefs `lut_addr_t` and `lut_data_t`;
  - function `rr_pick(valid, ptr)` returning the granted index and a found flag.
- One sub-module, `rr_arbiter`, is natural: combinational pick plus the rr_ptr register, with parameter N_REQ, inputs req/advance, and outputs one-hot grant and index. It is reusable for other shared encoder tables.
- lut_u itself is instantiated outside this block.

## Test plan
- After reset, single request: requester 2 requests addr 0x3C, with the LUT preloaded so that [0x3C]=0xBEEF. Expected: req_ready[2]=1 in T, lut_addr=0x3C in T+1, rsp_valid=4'b0100 and rsp_data=0xBEEF in T+2.
- All four requesters valid continuously from reset. Expected: grants follow 0,1,2,3,0,1,… with one response per cycle and no gaps, each response carrying its requester's address data.
- Requesters 1 and 3 valid, and rr_ptr=2 after a grant to 1. Expected: 3 is granted next, then 1, then 3.
- hold rises in the cycle after two accepts. Expected: req_ready goes to 0 immediately, both pending responses still appear in order, and there are no further responses until hold falls.
- reset pulses one cycle after an accept. Expected: no rsp_valid for that access, and all outputs hold their reset values the cycle after reset.
- Macro undefined: repeat the first scenario. Expected: rsp_valid=4'b0100 with rsp_data=0xBEEF in T+1.

Source files
------------

// File: rtl/lut_u_pkg.sv
// Shared definitions for lut_u access logic: LUT geometry, word/address
// types and the round-robin pick helper used by rr_arbiter.
package lut_u_pkg;

    localparam int unsigned LUT_DATA_WIDTH = 16;
    localparam int unsigned LUT_ADDR_WIDTH = 8;
    localparam int unsigned RR_MAX_REQ     = 8;

    typedef logic [LUT_ADDR_WIDTH-1:0] lut_addr_t;
    typedef logic [LUT_DATA_WIDTH-1:0] lut_data_t;
    typedef logic [2:0]                rr_idx_t;

    typedef struct packed {
        logic    found;
        rr_idx_t idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, scanning upward and wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input rr_idx_t ptr,
                                         input int unsigned n);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && !res.found && valid[j[2:0]]) begin
                res.found = 1'b1;
                res.idx   = j[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick from rr_ptr plus the pointer register.
// The pointer moves just past the granted requester whenever advance is set.
module rr_arbiter
    import lut_u_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       index
);

    localparam rr_idx_t LAST_IDX = rr_idx_t'(N_REQ - 1);

    rr_idx_t  rr_ptr;
    rr_pick_t pick;

    // Pick the first requester at or after rr_ptr and form the one-hot grant
    always_comb begin
        pick  = rr_pick(RR_MAX_REQ'(req), rr_ptr, N_REQ);
        index = pick.idx;
        grant = pick.found ? (N_REQ'(1) << pick.idx) : '0;
    end

    // Granted requester becomes lowest priority on the next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (advance && pick.found) begin
            rr_ptr <= (pick.idx == LAST_IDX) ? '0 : pick.idx + 3'd1;
        end
    end

endmodule

// File: rtl/lut_u_arbiter.sv
// Round-robin arbiter and read sequencer sharing one lut_u read port.
// Optional macro LUT_U_ARB_RSP_REG_EN: registered response stage (latency 2);
// when undefined the response is combinational from lut_q (latency 1).
module lut_u_arbiter
    import lut_u_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = LUT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = LUT_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]       lut_addr,
    input  logic [DATA_WIDTH-1:0]       lut_q,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data
);

    logic [N_REQ-1:0]      req_gated;
    logic [N_REQ-1:0]      grant;
    logic [2:0]            grant_idx;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic                  s1_valid;
    logic [2:0]            s1_id;
    logic [N_REQ-1:0]      s1_onehot;

    // New requests are offered to the arbiter only outside reset and hold
    always_comb begin
        req_gated = (reset || hold) ? '0 : req_valid;
        transfer  = |grant;
        req_ready = grant;
    end

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr_arbiter (
        .clk    (clk),
        .reset  (reset),
        .req    (req_gated),
        .advance(transfer),
        .grant  (grant),
        .index  (grant_idx)
    );

    // One-hot mux of the granted requester's address
    always_comb begin
        addr_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) addr_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Access stage: register the granted address onto the LUT and tag it
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            lut_addr <= '0;
        end else if (transfer) begin
            s1_valid <= 1'b1;
            s1_id    <= grant_idx;
            lut_addr <= addr_sel;
        end else begin
            s1_valid <= 1'b0;
        end
    end

    // Decode the in-flight access tag into the response strobe
    always_comb begin
        s1_onehot = s1_valid ? (N_REQ'(1) << s1_id) : '0;
    end

`ifdef LUT_U_ARB_RSP_REG_EN
    // Response stage: capture LUT word; data holds between responses
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= s1_onehot;
            if (s1_valid) rsp_data <= lut_q;
        end
    end
`else
    // Response passes straight through from the LUT in the access cycle
    always_comb begin
        rsp_valid = s1_onehot;
        rsp_data  = lut_q;
    end
`endif

endmodule

// File: tb/tb_lut_u_arbiter.sv
// Self-checking bench for lut_u_arbiter: vector table for grant order and
// lut_addr, a scoreboard queue for responses, and a random stress phase.
module tb_lut_u_arbiter;

`ifdef LUT_U_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic [7:0]  lut_addr;
    logic [15:0] lut_q;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;

    logic [15:0] lut_mem [256];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit mon_en     = 1'b0;

    typedef struct {
        int          due;
        logic [3:0]  oh;
        logic [15:0] data;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        logic       rst;
        logic       hld;
        logic [3:0] valid;
        logic [3:0] rdy;
        logic [7:0] la;
    } vec_t;
    vec_t vecs[22];

    lut_u_arbiter #(
        .N_REQ(4),
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hold     (hold),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .lut_addr (lut_addr),
        .lut_q    (lut_q),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data)
    );

    always #5 clk = ~clk;

    assign lut_q = lut_mem[lut_addr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: check due responses, drop flushed ones, record new transfers
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("rsp_valid", 32'(rsp_valid), 32'(sb[0].oh));
                check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                void'(sb.pop_front());
            end else begin
                check("rsp_idle", 32'(rsp_valid), 32'h0);
            end
            if (reset) begin
                while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        rsp_t e;
                        e.due  = cyc + LAT;
                        e.oh   = 4'(1 << i);
                        e.data = lut_mem[req_addr[i*8 +: 8]];
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) lut_mem[i] = 16'(i * 16'h0101) ^ 16'hA5C3;
        lut_mem[8'h3C] = 16'hBEEF;

        // requester addresses: 0:0x11 1:0x22 2:0x3C 3:0x44
        vecs[0]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h3C};
        vecs[2]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h3C};
        vecs[3]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 8'h3C};
        vecs[4]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 4'b1111, 4'b0010, 8'h11};
        vecs[6]  = '{1'b0, 1'b0, 4'b1111, 4'b0100, 8'h22};
        vecs[7]  = '{1'b0, 1'b0, 4'b1111, 4'b1000, 8'h3C};
        vecs[8]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 8'h44};
        vecs[9]  = '{1'b0, 1'b0, 4'b1010, 4'b0010, 8'h11};
        vecs[10] = '{1'b0, 1'b0, 4'b1010, 4'b1000, 8'h22};
        vecs[11] = '{1'b0, 1'b0, 4'b1010, 4'b0010, 8'h44};
        vecs[12] = '{1'b0, 1'b0, 4'b1010, 4'b1000, 8'h22};
        vecs[13] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 8'h44};
        vecs[14] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 8'h44};
        vecs[15] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 8'h44};
        vecs[16] = '{1'b0, 1'b0, 4'b1111, 4'b0001, 8'h44};
        vecs[17] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h11};
        vecs[18] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h11};
        vecs[19] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 8'h11};
        vecs[20] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 8'h11};
        vecs[21] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00};

        reset     = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = {8'h44, 8'h3C, 8'h22, 8'h11};

        @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_lut_addr", 32'(lut_addr), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
`ifdef LUT_U_ARB_RSP_REG_EN
        check("reset_rsp_data", 32'(rsp_data), 32'h0);
`else
        check("reset_rsp_data", 32'(rsp_data), 32'(lut_mem[0]));
`endif

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            reset     = vecs[k].rst;
            hold      = vecs[k].hld;
            req_valid = vecs[k].valid;
            @(negedge clk);
            check($sformatf("row%0d_ready", k), 32'(req_ready), 32'(vecs[k].rdy));
            check($sformatf("row%0d_lut_addr", k), 32'(lut_addr), 32'(vecs[k].la));
        end
        // cycle after the mid-operation reset: data back at its reset value
`ifdef LUT_U_ARB_RSP_REG_EN
        check("post_reset_rsp_data", 32'(rsp_data), 32'h0);
`else
        check("post_reset_rsp_data", 32'(rsp_data), 32'(lut_mem[0]));
`endif

        // random stress: responses checked by the scoreboard
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            hold      = ($urandom_range(0, 7) == 0);
            req_valid = 4'($urandom);
            req_addr  = $urandom;
            @(negedge clk);
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'h1);
            check("ready_subset", 32'(req_ready & ~req_valid), 32'h0);
            if (hold) check("ready_hold", 32'(req_ready), 32'h0);
        end

        @(posedge clk);
        #1;
        hold      = 1'b0;
        req_valid = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
